// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the multiplier issue stage and its helpers.
//   state_t : issue FSM state encoding (IDLE / ISSUE / RESP)
//   MULT_W  : default operand width, identical to the multiplier operand width
//   CNT_W   : default width of the activity counters
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      RESP  = 2'b10
   } state_t;

   localparam int MULT_W = 8;
   localparam int CNT_W  = 16;

endpackage

// File: rtl/mult_issue_ctrl_sat_counter.sv
// sat_counter
// Saturating up-counter used for power-characterisation activity statistics.
// Ports:
//   clk   in  : system clock
//   rst_n in  : asynchronous active-low reset, clears the count
//   inc   in  : increment request for this cycle
//   clr   in  : synchronous clear; beats a simultaneous increment
//   count out : current count, holds at all-ones once saturated
module sat_counter
   import mult_pkg::*;
#(
   parameter int CW = CNT_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] count
);

   // Clear has priority so a statistics reset is never lost to a concurrent op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {CW{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl
// Issue stage in front of the clock-gated multiplier. Accepts operand pairs
// over valid/ready, registers them onto the multiplier inputs and pulses the
// capture enable for one cycle. A pair identical to the previously computed
// one leaves the enable low, since the multiplier output already holds it.
// Ports:
//   clk, rst_n            : clock and asynchronous active-low reset
//   in_valid/in_ready     : upstream operand handshake
//   in_a, in_b            : operands
//   flush                 : forget the operand history (next op never skipped)
//   mult_a, mult_b        : registered operands to the multiplier
//   mult_en               : registered multiplier capture enable
//   res_valid/res_ready   : downstream result handshake
//   cnt_clr               : synchronous clear of both activity counters
//   active_cnt, gated_cnt : saturating counts of enabled / suppressed ops
// The multiplier captures on the falling clock edge, and its active-high
// reset must be tied to ~rst_n.
module mult_issue_ctrl
   import mult_pkg::*;
#(
   parameter int W       = MULT_W,
   parameter int CW      = CNT_W,
   parameter bit SKIP_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_a,
   input  logic [W-1:0]  in_b,
   input  logic          flush,
   output logic [W-1:0]  mult_a,
   output logic [W-1:0]  mult_b,
   output logic          mult_en,
   output logic          res_valid,
   input  logic          res_ready,
   input  logic          cnt_clr,
   output logic [CW-1:0] active_cnt,
   output logic [CW-1:0] gated_cnt
);

   state_t state;
   state_t next_state;
   logic   hist_valid;
   logic   accept;
   logic   skip;
   logic   issue_done;

   assign accept = in_valid & in_ready;

   // A flush on the accept edge forces the op to be computed.
   assign skip = SKIP_EN & hist_valid & ~flush &
                 (in_a == mult_a) & (in_b == mult_b);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; in RESP an accept already implies res_ready, which
   // gives back-to-back operation straight into ISSUE.
   always_comb begin
      next_state = IDLE;
      case (state)
         IDLE:    next_state = accept ? ISSUE : IDLE;
         ISSUE:   next_state = RESP;
         RESP: begin
            if (res_ready) begin
               next_state = accept ? ISSUE : IDLE;
            end else begin
               next_state = RESP;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      in_ready   = 1'b0;
      issue_done = 1'b0;
      case (state)
         IDLE:    in_ready = 1'b1;
         ISSUE:   issue_done = 1'b1;
         RESP:    in_ready = res_ready;
         default: in_ready = 1'b0;
      endcase
   end

   // Operands only move on accept, so they are stable while res_valid is high.
   // mult_en can only rise on accept and is cleared on the following edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mult_a  <= '0;
         mult_b  <= '0;
         mult_en <= 1'b0;
      end else begin
         mult_en <= accept & ~skip;
         if (accept) begin
            mult_a <= in_a;
            mult_b <= in_b;
         end
      end
   end

   // Result flag and operand history; flush beats the history set at ISSUE end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid  <= 1'b0;
         hist_valid <= 1'b0;
      end else begin
         if (issue_done) begin
            res_valid <= 1'b1;
         end else if ((state == RESP) && res_ready) begin
            res_valid <= 1'b0;
         end
         if (flush) begin
            hist_valid <= 1'b0;
         end else if (issue_done) begin
            hist_valid <= 1'b1;
         end
      end
   end

   sat_counter #(.CW(CW)) u_active_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (issue_done & mult_en),
      .clr   (cnt_clr),
      .count (active_cnt)
   );

   sat_counter #(.CW(CW)) u_gated_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (issue_done & ~mult_en),
      .clr   (cnt_clr),
      .count (gated_cnt)
   );

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb_mult_issue_ctrl
// Drives three instances from one stimulus stream: u0 (skipping, 16-bit
// counters), u1 (no skipping) and u2 (skipping, 3-bit counters to reach
// saturation quickly). A behavioural multiplier on u0 captures on the
// falling edge when mult_en is high.
module tb_mult_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_a = '0;
   logic [7:0] in_b = '0;
   logic       flush = 1'b0;
   logic       res_ready = 1'b0;
   logic       cnt_clr = 1'b0;

   logic        rdy0, en0, rv0;
   logic [7:0]  ma0, mb0;
   logic [15:0] act0, gat0;
   logic        rdy1, en1, rv1;
   logic [7:0]  ma1, mb1;
   logic [15:0] act1, gat1;
   logic        rdy2, en2, rv2;
   logic [7:0]  ma2, mb2;
   logic [2:0]  act2, gat2;
   logic [15:0] prod0;

   int check_count = 0;
   int fail_count  = 0;

   always #5 clk = ~clk;

   mult_issue_ctrl #(.W(8), .CW(16), .SKIP_EN(1'b1)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
      .in_a(in_a), .in_b(in_b), .flush(flush), .mult_a(ma0), .mult_b(mb0),
      .mult_en(en0), .res_valid(rv0), .res_ready(res_ready), .cnt_clr(cnt_clr),
      .active_cnt(act0), .gated_cnt(gat0));

   mult_issue_ctrl #(.W(8), .CW(16), .SKIP_EN(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
      .in_a(in_a), .in_b(in_b), .flush(flush), .mult_a(ma1), .mult_b(mb1),
      .mult_en(en1), .res_valid(rv1), .res_ready(res_ready), .cnt_clr(cnt_clr),
      .active_cnt(act1), .gated_cnt(gat1));

   mult_issue_ctrl #(.W(8), .CW(3), .SKIP_EN(1'b1)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
      .in_a(in_a), .in_b(in_b), .flush(flush), .mult_a(ma2), .mult_b(mb2),
      .mult_en(en2), .res_valid(rv2), .res_ready(res_ready), .cnt_clr(cnt_clr),
      .active_cnt(act2), .gated_cnt(gat2));

   // Behavioural clock-gated multiplier attached to u0
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod0 <= '0;
      end else if (en0) begin
         prod0 <= ma0 * mb0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      check_count++;
      if (obs !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One op from IDLE: accept, ISSUE, RESP, then consume and return to IDLE.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic fl, input logic exp_en0,
                                input logic exp_en1, input string tag);
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      flush = fl;
      tick();
      in_valid = 1'b0;
      flush = 1'b0;
      checkOutput({tag, " en0"}, 32'(en0), 32'(exp_en0));
      checkOutput({tag, " en1"}, 32'(en1), 32'(exp_en1));
      tick();
      checkOutput({tag, " rv0"}, 32'(rv0), 1);
      checkOutput({tag, " en0 off"}, 32'(en0), 0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      checkOutput({tag, " rv0 clr"}, 32'(rv0), 0);
      checkOutput({tag, " idle"}, 32'(rdy0), 1);
   endtask

   initial begin
      logic [7:0]  pa [5];
      logic [7:0]  pb [5];
      logic [15:0] pp [5];
      pa = '{8'h01, 8'h10, 8'h7F, 8'h12, 8'hFF};
      pb = '{8'h02, 8'h10, 8'h02, 8'h34, 8'hFF};
      pp = '{16'h0002, 16'h0100, 16'h00FE, 16'h03A8, 16'hFE01};

      // Reset values
      #3;
      checkOutput("rst en", 32'(en0), 0);
      checkOutput("rst rv", 32'(rv0), 0);
      checkOutput("rst ma", 32'(ma0), 0);
      checkOutput("rst act", 32'(act0), 0);
      #9 rst_n = 1'b1;
      #1;
      checkOutput("rst rdy", 32'(rdy0), 1);

      // First op 0F x 11, checked step by step
      in_valid = 1'b1;
      in_a = 8'h0F;
      in_b = 8'h11;
      tick();
      in_valid = 1'b0;
      checkOutput("op1 en", 32'(en0), 1);
      checkOutput("op1 rv early", 32'(rv0), 0);
      checkOutput("op1 busy", 32'(rdy0), 0);
      tick();
      checkOutput("op1 en pulse", 32'(en0), 0);
      checkOutput("op1 rv", 32'(rv0), 1);
      checkOutput("op1 prod", 32'(prod0), 32'h00FF);
      checkOutput("op1 act", 32'(act0), 1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      checkOutput("op1 done", 32'(rv0), 0);

      // Downstream stall holds result and operands
      in_valid = 1'b1;
      in_a = 8'h03;
      in_b = 8'h05;
      tick();
      in_a = 8'h77;
      in_b = 8'h66;
      tick();
      for (int i = 0; i < 10; i++) begin
         checkOutput("stall rv", 32'(rv0), 1);
         checkOutput("stall rdy", 32'(rdy0), 0);
         checkOutput("stall ma", 32'(ma0), 32'h03);
         checkOutput("stall mb", 32'(mb0), 32'h05);
         tick();
      end
      in_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      checkOutput("stall rv drop", 32'(rv0), 0);
      checkOutput("stall idle", 32'(rdy0), 1);

      // Repeated operands are gated only when skipping is enabled
      applyStimulus(8'hAA, 8'h55, 1'b0, 1'b1, 1'b1, "aa1");
      checkOutput("aa1 prod", 32'(prod0), 32'h3872);
      applyStimulus(8'hAA, 8'h55, 1'b0, 1'b0, 1'b1, "aa2");
      checkOutput("aa2 prod", 32'(prod0), 32'h3872);
      checkOutput("aa2 gat0", 32'(gat0), 1);
      checkOutput("aa2 act0", 32'(act0), 3);
      checkOutput("aa2 act1", 32'(act1), 4);
      checkOutput("aa2 gat1", 32'(gat1), 0);

      // Flush on the accept edge forces computation
      applyStimulus(8'hAA, 8'h55, 1'b1, 1'b1, 1'b1, "flush");
      checkOutput("flush act0", 32'(act0), 4);
      checkOutput("flush gat0", 32'(gat0), 1);

      // Back-to-back stream, one accept every two cycles
      in_valid = 1'b1;
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_a = pa[i];
         in_b = pb[i];
         tick();
         checkOutput("b2b en", 32'(en0), 1);
         checkOutput("b2b ma", 32'(ma0), 32'(pa[i]));
         checkOutput("b2b rv low", 32'(rv0), 0);
         if (i == 4) in_valid = 1'b0;
         tick();
         checkOutput("b2b rv", 32'(rv0), 1);
         checkOutput("b2b prod", 32'(prod0), 32'(pp[i]));
      end
      tick();
      res_ready = 1'b0;
      checkOutput("b2b idle", 32'(rv0), 0);
      checkOutput("b2b act0", 32'(act0), 9);
      checkOutput("b2b act1", 32'(act1), 10);
      checkOutput("sat act2", 32'(act2), 7);

      // Reset during ISSUE, then the same pair must not be skipped
      in_valid = 1'b1;
      in_a = 8'h44;
      in_b = 8'h02;
      tick();
      in_valid = 1'b0;
      checkOutput("pre-rst en", 32'(en0), 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async en", 32'(en0), 0);
      checkOutput("async act0", 32'(act0), 0);
      checkOutput("async act2", 32'(act2), 0);
      checkOutput("async ma", 32'(ma0), 0);
      #2 rst_n = 1'b1;
      tick();
      checkOutput("post-rst rv", 32'(rv0), 0);
      applyStimulus(8'h44, 8'h02, 1'b0, 1'b1, 1'b1, "post-rst");
      checkOutput("post-rst prod", 32'(prod0), 32'h0088);

      // Flush coinciding with ISSUE completion wipes the history
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checkOutput("skip en", 32'(en0), 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("skip gat0", 32'(gat0), 1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      applyStimulus(8'h44, 8'h02, 1'b0, 1'b1, 1'b1, "flush-late");

      // Clear beats a simultaneous increment
      in_valid = 1'b1;
      in_a = 8'h21;
      in_b = 8'h03;
      tick();
      in_valid = 1'b0;
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      checkOutput("clr act0", 32'(act0), 0);
      checkOutput("clr gat0", 32'(gat0), 0);
      checkOutput("clr act1", 32'(act1), 0);
      checkOutput("clr rv", 32'(rv0), 1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               check_count, fail_count);
      $finish;
   end

endmodule
